// File: rtl/rng_digit_gen.sv
// Random decimal-digit code generator: free-running LFSR with user-timed seeding,
// rejection sampling, optional wildcards and no-repeat mode, and a valid/ready result handshake.
module rng_digit_gen #(
    parameter int                N_DIGITS    = 4,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_INIT   = 16'hACE1,
    parameter int                WILD_THRESH = 1,
    parameter logic [3:0]        WILD_CODE   = 4'd10,
    parameter bit                NO_REPEAT   = 1'b0,
    parameter int                MAX_RETRY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_en,
    input  logic                  gen_req,
    input  logic                  digits_ready,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   wild_mask,
    output logic                  digits_valid,
    output logic                  busy
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [5:0]         WILD_LIM  = 6'(WILD_THRESH);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [LFSR_W-1:0]     lfsr_reg, lfsr_next;
    logic [LFSR_W-1:0]     seed_cnt_reg;
    logic                  seeded_reg;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [RETRY_W-1:0]    retry_reg, retry_next;
    logic [4*N_DIGITS-1:0] digits_reg, digits_next;
    logic [N_DIGITS-1:0]   wild_mask_reg, wild_mask_next;
    logic [9:0]            used_reg, used_next;
    logic                  valid_reg, valid_next;
    logic                  busy_reg, busy_next;

    logic [3:0] cand;
    logic [3:0] cand_mod;
    logic       is_wild;
    logic       in_range;
    logic       repeat_hit;
    logic [9:0] hit_vec;
    logic       clear;
    logic       wr_en;
    logic       acc_wild;
    logic [3:0] acc_val;

    // Seed capture takes priority over the shift; a zero count would lock the LFSR.
    always_comb begin
        if (seed_en && !seeded_reg) begin
            lfsr_next = (seed_cnt_reg == '0) ? SEED_INIT : seed_cnt_reg;
        end else begin
            lfsr_next = {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & TAPS)};
        end
    end

    assign cand     = lfsr_reg[3:0];
    assign is_wild  = ({1'b0, lfsr_reg[4:0]} < WILD_LIM);
    assign in_range = (cand <= 4'd9);
    assign cand_mod = in_range ? cand : (cand - 4'd10);

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_used
            assign hit_vec[gi]   = used_reg[gi] && (cand == 4'(gi));
            assign used_next[gi] = clear ? 1'b0 :
                                   (wr_en && !acc_wild && (acc_val == 4'(gi))) ? 1'b1 :
                                   used_reg[gi];
        end
    endgenerate

    assign repeat_hit = NO_REPEAT && (|hit_vec);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        retry_next = retry_reg;
        clear      = 1'b0;
        wr_en      = 1'b0;
        acc_wild   = 1'b0;
        acc_val    = cand;
        case (state_reg)
            IDLE: begin
                if (gen_req) begin
                    state_next = DRAW;
                    idx_next   = '0;
                    retry_next = '0;
                    clear      = 1'b1;
                end
            end
            DRAW: begin
                if (is_wild) begin
                    wr_en    = 1'b1;
                    acc_wild = 1'b1;
                    acc_val  = WILD_CODE;
                end else if (in_range && !repeat_hit) begin
                    wr_en   = 1'b1;
                    acc_val = cand;
                end else if (retry_reg == RETRY_MAX) begin
                    // Forced acceptance bounds latency; duplicates are tolerated here.
                    wr_en   = 1'b1;
                    acc_val = cand_mod;
                end else begin
                    retry_next = retry_reg + 1'b1;
                end
                if (wr_en) begin
                    retry_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                if (valid_reg && digits_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_lane
            logic lane_wr;
            assign lane_wr = wr_en && (idx_reg == IDX_W'(gi));
            assign digits_next[4*gi +: 4] = clear   ? 4'd0    :
                                            lane_wr ? acc_val :
                                            digits_reg[4*gi +: 4];
            assign wild_mask_next[gi]     = clear   ? 1'b0     :
                                            lane_wr ? acc_wild :
                                            wild_mask_reg[gi];
        end
    endgenerate

    // Valid is raised one cycle after entering DONE so the result is settled when offered.
    assign valid_next = (state_reg == DONE) && (state_next == DONE);
    assign busy_next  = (state_next != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            lfsr_reg      <= SEED_INIT;
            seed_cnt_reg  <= '0;
            seeded_reg    <= 1'b0;
            idx_reg       <= '0;
            retry_reg     <= '0;
            digits_reg    <= '0;
            wild_mask_reg <= '0;
            used_reg      <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lfsr_reg      <= lfsr_next;
            seed_cnt_reg  <= seed_cnt_reg + 1'b1;
            if (seed_en) begin
                seeded_reg <= 1'b1;
            end
            idx_reg       <= idx_next;
            retry_reg     <= retry_next;
            digits_reg    <= digits_next;
            wild_mask_reg <= wild_mask_next;
            used_reg      <= used_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
        end
    end

    assign digits       = digits_reg;
    assign wild_mask    = wild_mask_reg;
    assign digits_valid = valid_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_rng_digit_gen.sv
// Directed bench for rng_digit_gen: four configurations sharing clock, reset and seed,
// checked against hand values and a cycle-level LFSR/draw model.
module tb_rng_digit_gen;

    localparam int BUDGET = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_en = 1'b0;
    logic [3:0]  gen_req = 4'h0;
    logic [3:0]  ready = 4'hF;

    logic [15:0] dig0, dig1, dig3;
    logic [39:0] dig2;
    logic [3:0]  wm0, wm1, wm3;
    logic [9:0]  wm2;
    logic [3:0]  valid, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rng_digit_gen #(.WILD_THRESH(0)) u_base (
        .clk(clk), .rst(rst), .seed_en(seed_en), .gen_req(gen_req[0]), .digits_ready(ready[0]),
        .digits(dig0), .wild_mask(wm0), .digits_valid(valid[0]), .busy(busy[0]));

    rng_digit_gen #(.WILD_THRESH(32)) u_wild (
        .clk(clk), .rst(rst), .seed_en(seed_en), .gen_req(gen_req[1]), .digits_ready(ready[1]),
        .digits(dig1), .wild_mask(wm1), .digits_valid(valid[1]), .busy(busy[1]));

    rng_digit_gen #(.N_DIGITS(10), .WILD_THRESH(0), .NO_REPEAT(1), .MAX_RETRY(255)) u_norep (
        .clk(clk), .rst(rst), .seed_en(seed_en), .gen_req(gen_req[2]), .digits_ready(ready[2]),
        .digits(dig2), .wild_mask(wm2), .digits_valid(valid[2]), .busy(busy[2]));

    rng_digit_gen #(.WILD_THRESH(0), .MAX_RETRY(0)) u_fast (
        .clk(clk), .rst(rst), .seed_en(seed_en), .gen_req(gen_req[3]), .digits_ready(ready[3]),
        .digits(dig3), .wild_mask(wm3), .digits_valid(valid[3]), .busy(busy[3]));

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    // Free-running LFSR and seed counter as the generator should see them.
    logic [15:0] m_lfsr, m_cnt;
    logic        m_seeded;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr   <= 16'hACE1;
            m_cnt    <= 16'd0;
            m_seeded <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 16'd1;
            if (seed_en && !m_seeded) begin
                m_lfsr   <= (m_cnt == 16'd0) ? 16'hACE1 : m_cnt;
                m_seeded <= 1'b1;
            end else begin
                m_lfsr <= lfsr_step(m_lfsr);
            end
        end
    end

    // Expected draw starting from the LFSR value seen at the first evaluation.
    function automatic void model_draw(input logic [15:0] start, input int n, input int thresh,
                                       input bit norep, input int maxr,
                                       output logic [63:0] dig, output logic [15:0] msk,
                                       output int lat);
        logic [15:0] v;
        logic [15:0] used;
        logic [3:0]  lo4;
        logic [3:0]  val;
        bit          acc;
        int          idx, retry, evals;
        v = start; used = '0; dig = '0; msk = '0;
        idx = 0; retry = 0; evals = 0;
        while (idx < n && evals < 100000) begin
            evals++;
            lo4 = v[3:0];
            val = 4'd0;
            acc = 1'b1;
            if (int'(v[4:0]) < thresh) begin
                val = 4'd10;
                msk[idx] = 1'b1;
            end else if (lo4 <= 4'd9 && !(norep && used[lo4])) begin
                val = lo4;
            end else if (retry == maxr) begin
                val = (lo4 > 4'd9) ? lo4 - 4'd10 : lo4;
            end else begin
                acc = 1'b0;
                retry++;
            end
            if (acc) begin
                dig[4*idx +: 4] = val;
                if (!msk[idx]) used[val] = 1'b1;
                retry = 0;
                idx++;
            end
            v = lfsr_step(v);
        end
        lat = evals + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        gen_req = 4'h0;
        seed_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request (optionally with a seed) and waits for valid; returns the first-evaluation LFSR.
    task automatic draw(input int k, input bit with_seed, output logic [15:0] start, output int cnt);
        gen_req[k] = 1'b1;
        seed_en = with_seed;
        @(negedge clk);
        gen_req[k] = 1'b0;
        seed_en = 1'b0;
        start = m_lfsr;
        cnt = 0;
        while (valid[k] !== 1'b1 && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %h want 0", valid); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (dig0 !== 16'h0) begin errors++; $display("FAIL reset_digits got %h want 0", dig0); end
        checks++; if (wm1 !== 4'h0) begin errors++; $display("FAIL reset_wild_mask got %h want 0", wm1); end
        checks++; if (dig2 !== 40'h0) begin errors++; $display("FAIL reset_digits_norep got %h want 0", dig2); end
        $display("test_reset: valid=%h busy=%h", valid, busy);
    endtask

    task automatic test_unseeded_draw();
        logic [15:0] s;
        logic [63:0] ed;
        logic [15:0] em;
        int c, el;
        bit ok;
        do_reset();
        repeat (4) @(negedge clk);
        draw(0, 1'b0, s, c);
        model_draw(s, 4, 0, 1'b0, 15, ed, em, el);
        checks++; if (c !== el) begin errors++; $display("FAIL unseeded_latency got %0d want %0d", c, el); end
        checks++; if (dig0 !== ed[15:0]) begin errors++; $display("FAIL unseeded_digits got %h want %h", dig0, ed[15:0]); end
        checks++; if (wm0 !== 4'h0) begin errors++; $display("FAIL unseeded_wild_mask got %h want 0", wm0); end
        ok = 1'b1;
        for (int d = 0; d < 4; d++) if (dig0[4*d +: 4] > 4'd9) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL unseeded_range got %h want all digits <=9", dig0); end
        @(negedge clk);
        checks++; if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL unseeded_release got valid=%b busy=%b want 0 0", valid[0], busy[0]); end
        $display("test_unseeded_draw: start=%h digits=%h latency=%0d", s, dig0, c);
    endtask

    task automatic test_seed_zero();
        logic [15:0] s;
        logic [63:0] ed;
        logic [15:0] em;
        int c, el;
        do_reset();
        seed_en = 1'b1;
        @(negedge clk);
        seed_en = 1'b0;
        repeat (3) @(negedge clk);
        draw(0, 1'b0, s, c);
        model_draw(s, 4, 0, 1'b0, 15, ed, em, el);
        checks++; if (c !== el) begin errors++; $display("FAIL seed0_latency got %0d want %0d", c, el); end
        checks++; if (dig0 !== ed[15:0]) begin errors++; $display("FAIL seed0_digits got %h want %h", dig0, ed[15:0]); end
        $display("test_seed_zero: first draw digits=%h", dig0);
        repeat (90) @(negedge clk);
        seed_en = 1'b1;
        @(negedge clk);
        seed_en = 1'b0;
        repeat (4) @(negedge clk);
        draw(0, 1'b0, s, c);
        model_draw(s, 4, 0, 1'b0, 15, ed, em, el);
        checks++; if (c !== el) begin errors++; $display("FAIL reseed_latency got %0d want %0d", c, el); end
        checks++; if (dig0 !== ed[15:0]) begin errors++; $display("FAIL reseed_ignored_digits got %h want %h", dig0, ed[15:0]); end
        $display("test_seed_zero: second draw digits=%h", dig0);
    endtask

    task automatic test_seed_with_req();
        logic [15:0] s;
        logic [63:0] ed;
        logic [15:0] em;
        int c, el;
        do_reset();
        repeat (20) @(negedge clk);
        draw(0, 1'b1, s, c);
        model_draw(s, 4, 0, 1'b0, 15, ed, em, el);
        checks++; if (c !== el) begin errors++; $display("FAIL seed_req_latency got %0d want %0d", c, el); end
        checks++; if (dig0 !== ed[15:0]) begin errors++; $display("FAIL seed_req_digits got %h want %h", dig0, ed[15:0]); end
        $display("test_seed_with_req: start=%h digits=%h", s, dig0);
    endtask

    task automatic test_wildcard();
        logic [15:0] s;
        int c;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            repeat (3 + 4*j) @(negedge clk);
            draw(1, 1'b0, s, c);
            checks++; if (c !== 5) begin errors++; $display("FAIL wild_latency got %0d want 5", c); end
            checks++; if (dig1 !== 16'hAAAA) begin errors++; $display("FAIL wild_digits got %h want aaaa", dig1); end
            checks++; if (wm1 !== 4'hF) begin errors++; $display("FAIL wild_mask got %h want f", wm1); end
            @(negedge clk);
            $display("test_wildcard: draw %0d digits=%h mask=%h", j, dig1, wm1);
        end
    endtask

    task automatic test_max_retry0();
        logic [15:0] s;
        logic [63:0] ed;
        logic [15:0] em;
        int c, el;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            repeat (j*5 + 1) @(negedge clk);
            draw(3, 1'b0, s, c);
            model_draw(s, 4, 0, 1'b0, 0, ed, em, el);
            checks++; if (c !== 5) begin errors++; $display("FAIL fast_latency got %0d want 5", c); end
            checks++; if (dig3 !== ed[15:0]) begin errors++; $display("FAIL fast_digits got %h want %h", dig3, ed[15:0]); end
            @(negedge clk);
            $display("test_max_retry0: start=%h digits=%h", s, dig3);
        end
    endtask

    task automatic test_no_repeat();
        logic [15:0] s;
        logic [63:0] ed;
        logic [15:0] em;
        logic [15:0] seen;
        int c, el;
        for (int i = 0; i < 50; i++) begin
            do_reset();
            repeat (i*3 + 2) @(negedge clk);
            seed_en = 1'b1;
            @(negedge clk);
            seed_en = 1'b0;
            @(negedge clk);
            draw(2, 1'b0, s, c);
            model_draw(s, 10, 0, 1'b1, 255, ed, em, el);
            seen = '0;
            for (int d = 0; d < 10; d++) seen[dig2[4*d +: 4]] = 1'b1;
            checks++; if (seen !== 16'h03FF) begin errors++; $display("FAIL norep_perm got %h want permutation of 0..9", dig2); end
            checks++; if (dig2 !== ed[39:0] || c !== el) begin errors++; $display("FAIL norep_model got %h/%0d want %h/%0d", dig2, c, ed[39:0], el); end
            checks++; if (wm2 !== 10'h0) begin errors++; $display("FAIL norep_wild_mask got %h want 0", wm2); end
            $display("test_no_repeat: draw %0d digits=%h latency=%0d", i, dig2, c);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic [63:0] ed;
        logic [15:0] em;
        int c, el;
        do_reset();
        ready[0] = 1'b0;
        repeat (2) @(negedge clk);
        draw(0, 1'b0, s, c);
        model_draw(s, 4, 0, 1'b0, 15, ed, em, el);
        checks++; if (c !== el) begin errors++; $display("FAIL bp_latency got %0d want %0d", c, el); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 12) gen_req[0] = 1'b1;
            @(negedge clk);
            gen_req[0] = 1'b0;
            checks++;
            if (valid[0] !== 1'b1 || dig0 !== ed[15:0] || wm0 !== 4'h0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b d=%h m=%h want v=1 d=%h m=0", i, valid[0], dig0, wm0, ed[15:0]);
            end
        end
        ready[0] = 1'b1;
        @(negedge clk);
        checks++; if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", valid[0], busy[0]); end
        repeat (3) @(negedge clk);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL bp_dropped_req got busy=%b want 0", busy[0]); end
        $display("test_backpressure: held digits=%h for 20 cycles", ed[15:0]);
    endtask

    task automatic test_reset_mid_draw();
        logic [15:0] s;
        int c;
        do_reset();
        repeat (2) @(negedge clk);
        gen_req[1] = 1'b1;
        @(negedge clk);
        gen_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy[1] !== 1'b1 || dig1 !== 16'h00AA) begin errors++; $display("FAIL mid_draw_partial got busy=%b d=%h want 1 00aa", busy[1], dig1); end
        rst = 1'b1;
        #1;
        checks++; if (dig1 !== 16'h0 || wm1 !== 4'h0) begin errors++; $display("FAIL mid_rst_outputs got d=%h m=%h want 0 0", dig1, wm1); end
        checks++; if (valid[1] !== 1'b0 || busy[1] !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got v=%b b=%b want 0 0", valid[1], busy[1]); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy[1] !== 1'b0 || valid[1] !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got b=%b v=%b want 0 0", busy[1], valid[1]); end
        draw(1, 1'b0, s, c);
        checks++; if (c !== 5 || dig1 !== 16'hAAAA) begin errors++; $display("FAIL post_rst_draw got %0d/%h want 5/aaaa", c, dig1); end
        $display("test_reset_mid_draw: post-reset draw digits=%h latency=%0d", dig1, c);
    endtask

    initial begin
        test_reset();
        test_unseeded_draw();
        test_seed_zero();
        test_seed_with_req();
        test_wildcard();
        test_max_retry0();
        test_backpressure();
        test_reset_mid_draw();
        test_no_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
